// File: rtl/chip8_tile_video_mux.sv
// Tiles NUM_CH CHIP-8 framebuffers onto the HDMI raster and classifies each pixel.
// Optional FOCUS_BLINK_EN: focus border blinks with frame_cnt[5] (32 frames on, 32 off).
module chip8_tile_video_mux #(
    parameter int NUM_CH     = 4,
    parameter int GRID_COLS  = 2,
    parameter int SCALE_LOG2 = 3,
    parameter int H_ORIGIN   = 128,
    parameter int V_ORIGIN   = 104,
    parameter int RD_LAT     = 2,
    parameter int BORDER_W   = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW        = CH_W + 8
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic [2:0]    focus_sel_in,
    input  logic [7:0]    fb_data_in,
    output logic [AW-1:0] fb_addr_out,
    output logic [1:0]    pixel_out
);

    localparam int S         = SCALE_LOG2;
    localparam int TXW       = 6 + S;
    localparam int TYW       = 5 + S;
    localparam int TILE_W    = 64 << S;
    localparam int TILE_H    = 32 << S;
    localparam int GRID_ROWS = (NUM_CH + GRID_COLS - 1) / GRID_COLS;
    localparam int GRID_W    = GRID_COLS * TILE_W;
    localparam int GRID_H    = GRID_ROWS * TILE_H;

    logic             w_frame_start;
    logic [2:0]       w_focus_eff;
    logic [11:0]      w_rel_h;
    logic [11:0]      w_rel_v;
    logic [TXW-1:0]   w_tx;
    logic [TYW-1:0]   w_ty;
    logic [5:0]       w_px;
    logic [4:0]       w_py;
    int               w_col;
    int               w_row;
    int               w_ch_int;
    logic [CH_W-1:0]  w_ch;
    logic             w_in_grid;
    logic             w_edge;
    logic             w_focus_hit;
    logic             w_blink_on;
    logic             w_border;

    logic [2:0]       r_focus;
    logic [5:0]       r_frame_cnt;
    logic             r_s1_valid;
    logic             r_s1_border;
    logic [CH_W-1:0]  r_s1_ch;
    logic [4:0]       r_s1_py;
    logic [5:0]       r_s1_px;

    assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    // A frame-start cycle that is also in the grid must already see the new focus.
    assign w_focus_eff   = w_frame_start ? focus_sel_in : r_focus;

    assign w_rel_h = {1'b0, hcount_in} - 12'(H_ORIGIN);
    assign w_rel_v = {2'b00, vcount_in} - 12'(V_ORIGIN);
    assign w_tx    = w_rel_h[TXW-1:0];
    assign w_ty    = w_rel_v[TYW-1:0];
    assign w_px    = w_rel_h[S +: 6];
    assign w_py    = w_rel_v[S +: 5];

`ifdef FOCUS_BLINK_EN
    logic [5:0] w_cnt_eff;
    assign w_cnt_eff  = w_frame_start ? (r_frame_cnt + 6'd1) : r_frame_cnt;
    assign w_blink_on = ~w_cnt_eff[5];
`else
    assign w_blink_on = 1'b1;
`endif

    always_comb begin
        w_col       = int'(w_rel_h >> TXW);
        w_row       = int'(w_rel_v >> TYW);
        w_ch_int    = w_row * GRID_COLS + w_col;
        w_ch        = w_ch_int[CH_W-1:0];
        // Sign bits rule out the left/top margins before the magnitude compares.
        w_in_grid   = !w_rel_h[11] && !w_rel_v[11] &&
                      (int'(w_rel_h) < GRID_W) && (int'(w_rel_v) < GRID_H) &&
                      (w_ch_int < NUM_CH);
        w_edge      = (int'(w_tx) < BORDER_W) || (int'(w_tx) >= TILE_W - BORDER_W) ||
                      (int'(w_ty) < BORDER_W) || (int'(w_ty) >= TILE_H - BORDER_W);
        w_focus_hit = (int'(w_focus_eff) < NUM_CH) && (w_ch_int == int'(w_focus_eff));
        w_border    = w_in_grid && w_edge && w_focus_hit && w_blink_on;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_focus     <= 3'd0;
            r_frame_cnt <= 6'd0;
        end else if (w_frame_start) begin
            r_focus     <= focus_sel_in;
            r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid  <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_ch     <= '0;
            r_s1_py     <= 5'd0;
            r_s1_px     <= 6'd0;
        end else begin
            r_s1_valid  <= w_in_grid;
            r_s1_border <= w_border;
            r_s1_ch     <= w_ch;
            r_s1_py     <= w_py;
            r_s1_px     <= w_px;
        end
    end

    // The address holds outside the grid so the memory sees no spurious reads.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fb_addr_out <= '0;
        end else if (r_s1_valid) begin
            fb_addr_out <= {r_s1_ch, r_s1_py, r_s1_px[5:3]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            logic       r_valid;
            logic       r_border;
            logic [2:0] r_bit;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        r_valid  <= 1'b0;
                        r_border <= 1'b0;
                        r_bit    <= 3'd0;
                    end else begin
                        r_valid  <= r_s1_valid;
                        r_border <= r_s1_border;
                        r_bit    <= r_s1_px[2:0];
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        r_valid  <= 1'b0;
                        r_border <= 1'b0;
                        r_bit    <= 3'd0;
                    end else begin
                        r_valid  <= g_pipe[gi-1].r_valid;
                        r_border <= g_pipe[gi-1].r_border;
                        r_bit    <= g_pipe[gi-1].r_bit;
                    end
                end
            end
        end
    endgenerate

    // Bit 7 of each byte is the leftmost pixel of its 8-pixel group.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_out <= 2'b00;
        end else if (!g_pipe[RD_LAT-1].r_valid) begin
            pixel_out <= 2'b00;
        end else if (g_pipe[RD_LAT-1].r_border) begin
            pixel_out <= 2'b11;
        end else if (fb_data_in[3'd7 - g_pipe[RD_LAT-1].r_bit]) begin
            pixel_out <= 2'b10;
        end else begin
            pixel_out <= 2'b01;
        end
    end

endmodule

// File: tb/tb_chip8_tile_video_mux.sv
// Scoreboard bench for chip8_tile_video_mux at default parameters.
module tb_chip8_tile_video_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [2:0]  focus_sel;
    logic [7:0]  fb_data;
    logic [9:0]  fb_addr;
    logic [1:0]  pixel;

    always #5 clk = ~clk;

    chip8_tile_video_mux dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .focus_sel_in (focus_sel),
        .fb_data_in   (fb_data),
        .fb_addr_out  (fb_addr),
        .pixel_out    (pixel)
    );

    // Memory with one register stage: data is sampled by the DUT RD_LAT=2 edges after the address.
    logic [7:0] tb_mem [0:1023];
    always @(posedge clk) fb_data <= tb_mem[fb_addr];

    typedef struct {
        logic [1:0] pix;
        logic [9:0] addr;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       tag_now = 1'b0;
    logic [3:0] tag_sr  = 4'd0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] cur_addr = 10'd0;
    int         n_frames = 0;

    always @(posedge clk) tag_sr <= {tag_sr[2:0], tag_now};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a tag launched with the stimulus reaches tag_sr[3] when pixel_out is due.
    always @(negedge clk) begin
        if (tag_sr[3]) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow: output with no expected entry");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_pix"}, int'(pixel), int'(mon_e.pix));
                check({mon_e.name, "_addr"}, int'(fb_addr), int'(mon_e.addr));
                $display("txn %-12s pixel=%b addr=0x%03h (exp %b / 0x%03h)",
                         mon_e.name, pixel, fb_addr, mon_e.pix, mon_e.addr);
            end
        end
    end

    task automatic issue(input int h, input int v, input logic [1:0] pix,
                         input logic [9:0] addr, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        hcount = h[10:0];
        vcount = v[9:0];
        if (h == 0 && v == 0) n_frames++;
        e.pix  = pix;
        e.addr = addr;
        e.name = name;
        exp_q.push_back(e);
        cur_addr = addr;
        tag_now  = 1'b1;
        @(posedge clk);
        #1;
        tag_now = 1'b0;
        hcount  = 11'd1400;
        vcount  = 10'd200;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 8'h00;
        rst_n     = 1'b0;
        hcount    = 11'd1400;
        vcount    = 10'd200;
        focus_sel = 3'd7;
        repeat (2) @(posedge clk);
        #2;
        check("reset_pix", int'(pixel), 0);
        check("reset_addr", int'(fb_addr), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Focus latch resets to 0: top-left corner of tile 0 is border.
        tb_mem[10'h000] = 8'h80;
        issue(128, 104, 2'b11, 10'h000, "rst_focus0");
        issue(0, 0, 2'b00, cur_addr, "frame_f7");
        issue(128, 104, 2'b10, 10'h000, "t0_on");
        tb_mem[10'h000] = 8'h7F;
        issue(128, 104, 2'b01, 10'h000, "t0_off");
        tb_mem[10'h119] = 8'h40;
        issue(712, 128, 2'b10, 10'h119, "t1_on");
        tb_mem[10'h119] = 8'hBF;
        issue(712, 128, 2'b01, 10'h119, "t1_off");

        // Outside the grid: class 00 and the address holds.
        issue(127, 200, 2'b00, cur_addr, "left_out");
        issue(1152, 200, 2'b00, cur_addr, "right_out");
        issue(300, 616, 2'b00, cur_addr, "below_out");
        issue(1400, 200, 2'b00, cur_addr, "blanking");
        tb_mem[10'h3FF] = 8'h01;
        issue(1151, 615, 2'b10, 10'h3FF, "last_px");

        // Mid-frame focus change must not show until the next frame start.
        focus_sel = 3'd2;
        tb_mem[10'h200] = 8'h80;
        issue(128, 360, 2'b10, 10'h200, "mid_f2_a");
        issue(639, 400, 2'b01, 10'h22F, "mid_f2_b");
        issue(0, 0, 2'b00, cur_addr, "frame_f2");
        issue(128, 360, 2'b11, 10'h200, "brd_corner");
        issue(129, 360, 2'b11, 10'h200, "brd_w1");
        issue(130, 362, 2'b10, 10'h200, "brd_inside");
        issue(639, 400, 2'b11, 10'h22F, "brd_right");
        issue(640, 400, 2'b01, 10'h328, "t3_nofocus");
        issue(1151, 615, 2'b10, 10'h3FF, "t3_last");

        // Asynchronous reset mid-cycle, no clock edge before sampling.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pix", int'(pixel), 0);
        check("async_rst_addr", int'(fb_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cur_addr = 10'd0;
        n_frames = 0;
        issue(712, 128, 2'b01, 10'h119, "post_rst");
        issue(129, 105, 2'b11, 10'h000, "post_rst_f0");

        // Focus value beyond NUM_CH disables the border.
        focus_sel = 3'd4;
        issue(0, 0, 2'b00, cur_addr, "frame_f4");
        tb_mem[10'h000] = 8'h7F;
        issue(128, 104, 2'b01, 10'h000, "focus_off");

`ifdef FOCUS_BLINK_EN
        focus_sel = 3'd0;
        for (int f = 0; f < 64; f++) begin
            issue(0, 0, 2'b00, cur_addr, "blink_fs");
            issue(128, 104, ((n_frames % 64) < 32) ? 2'b11 : 2'b01, 10'h000, "blink_px");
        end
`endif

        repeat (8) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
